// File: rtl/tile_fetch.sv
// tile_fetch -- fetches a tile of TILE_ROWS BRAM words starting at a base
// address and streams each word out as WPB lanes of DATA_W bits, lane 0
// being the least-significant slice of the word.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : one-cycle fetch request, only honoured while idle
//   abort        : synchronous cancel; returns to idle with no done pulse
//   base_addr    : tile base address, sampled when start is accepted
//   bram_en      : BRAM read enable (one cycle per word)
//   bram_addr    : BRAM read address, wraps modulo MEM_DEPTH
//   bram_rdata   : BRAM read data, valid the cycle after bram_en
//   out_data     : current lane
//   out_valid    : lane valid
//   out_ready    : consumer accepts the lane
//   out_last     : final lane of the tile
//   busy         : high whenever not idle
//   done         : one-cycle completion pulse
module tile_fetch #(
   parameter int DATA_W    = 16,
   parameter int BRAM_W    = 64,
   parameter int MEM_DEPTH = 256,
   parameter int TILE_ROWS = 2,
   localparam int WPB      = BRAM_W / DATA_W,
   localparam int AW       = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [AW-1:0]     base_addr,
   output logic              bram_en,
   output logic [AW-1:0]     bram_addr,
   input  logic [BRAM_W-1:0] bram_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   // Counter widths sized to hold TILE_ROWS-1 and WPB-1 (at least one bit).
   localparam int RW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
   localparam int LW = (WPB > 1) ? $clog2(WPB) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      WAIT   = 3'd2,
      UNPACK = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t                        state, state_nx;

   // Datapath strobes decoded by the FSM.
   logic                          accept;    // start taken in IDLE
   logic                          capture;   // latch bram_rdata into word
   logic                          lane_adv;  // move to next lane of word
   logic                          row_adv;   // move to next word of tile

   // addr tracks (base + row_cnt) mod MEM_DEPTH incrementally, so no
   // adder/modulo on the address path.
   logic [AW-1:0]                 addr;
   logic [RW-1:0]                 row_cnt;
   logic [LW-1:0]                 lane_idx;
   logic [WPB-1:0][DATA_W-1:0]    word;

   logic                          last_lane;
   logic                          last_row;

   assign last_lane = (lane_idx == LW'(WPB - 1));
   assign last_row  = (row_cnt  == RW'(TILE_ROWS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Outputs are decoded from state only, so everything is zero in IDLE
   // and hence zero the instant reset forces IDLE.
   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      capture   = 1'b0;
      lane_adv  = 1'b0;
      row_adv   = 1'b0;
      bram_en   = 1'b0;
      bram_addr = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            // abort wins over a coincident start
            if (start && !abort) begin
               accept   = 1'b1;
               state_nx = REQ;
            end
         end
         REQ: begin
            bram_en   = 1'b1;
            bram_addr = addr;
            state_nx  = WAIT;
         end
         WAIT: begin
            capture  = 1'b1;
            state_nx = UNPACK;
         end
         UNPACK: begin
            out_valid = 1'b1;
            out_data  = word[lane_idx];
            out_last  = last_lane && last_row;
            if (out_ready) begin
               if (!last_lane) begin
                  lane_adv = 1'b1;
               end else if (!last_row) begin
                  // next read only once every lane of this word is taken
                  row_adv  = 1'b1;
                  state_nx = REQ;
               end else begin
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = IDLE;
         end
      endcase
      // Cancel drops any progress made in the same cycle, including a
      // lane handshake.
      if (abort && (state != IDLE)) begin
         state_nx = IDLE;
         capture  = 1'b0;
         lane_adv = 1'b0;
         row_adv  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= '0;
         row_cnt  <= '0;
         lane_idx <= '0;
         word     <= '0;
      end else begin
         if (accept) begin
            addr    <= base_addr;
            row_cnt <= '0;
         end
         if (row_adv) begin
            row_cnt <= row_cnt + 1'b1;
            addr    <= (addr == AW'(MEM_DEPTH - 1)) ? '0 : addr + 1'b1;
         end
         if (capture) begin
            word     <= bram_rdata;
            lane_idx <= '0;
         end
         if (lane_adv) lane_idx <= lane_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_tile_fetch.sv
// tb_tile_fetch -- randomized and directed bench for tile_fetch with a
// transaction-level reference: expected addresses and lanes are queued
// from the memory image when a tile starts, and tile duration is checked
// against the closed-form cycle count plus observed stall cycles.
module tb_tile_fetch;
   localparam int DW  = 16;
   localparam int BW  = 64;
   localparam int DEP = 256;
   localparam int TR  = 2;
   localparam int WPB = BW / DW;

   logic          clk, rst_n, start, abort, out_ready;
   logic [7:0]    base_addr, bram_addr;
   logic          bram_en, out_valid, out_last, busy, done;
   logic [BW-1:0] bram_rdata;
   logic [DW-1:0] out_data;

   tile_fetch #(.DATA_W(DW), .BRAM_W(BW), .MEM_DEPTH(DEP), .TILE_ROWS(TR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .base_addr(base_addr), .bram_en(bram_en), .bram_addr(bram_addr),
      .bram_rdata(bram_rdata), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: one-cycle read latency, garbage when not enabled.
   logic [BW-1:0] mem [DEP];
   always @(posedge clk)
      bram_rdata <= bram_en ? mem[bram_addr] : {$urandom, $urandom};

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference state for the tile in flight.
   logic [7:0]    exp_addr[$];
   logic [DW-1:0] exp_data[$];
   bit            exp_last[$];
   logic [7:0]    obs_addr[$];
   logic [DW-1:0] obs_data[$];
   bit            obs_last[$];
   int            stalls, busy_cyc, done_cnt;

   // Compare process: samples at negedge, away from the active edge.
   initial begin
      done_cnt = 0;
      forever begin
         @(negedge clk);
         if (busy) busy_cyc++;
         if (!busy) chk("idle_outs", {bram_en, out_valid, out_last, done}, 0);
         if (bram_en) begin
            chk("en_vs_valid", out_valid, 0);
            if (exp_addr.size() == 0) chk("bram_extra_read", 1, 0);
            else begin
               // previous word fully drained before the next read
               chk("read_after_drain", exp_data.size(), exp_addr.size() * WPB);
               chk("bram_addr", bram_addr, exp_addr[0]);
               obs_addr.push_back(bram_addr);
               void'(exp_addr.pop_front());
            end
         end
         if (out_valid) begin
            if (exp_data.size() == 0) chk("lane_extra", 1, 0);
            else begin
               chk("out_data", out_data, exp_data[0]);
               chk("out_last", out_last, exp_last[0]);
               if (out_ready && !abort) begin
                  obs_data.push_back(out_data);
                  obs_last.push_back(out_last);
                  void'(exp_data.pop_front());
                  void'(exp_last.pop_front());
               end else if (!out_ready) stalls++;
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_after_all", exp_data.size(), 0);
         end
      end
   end

   task automatic flush();
      exp_addr.delete(); exp_data.delete(); exp_last.delete();
   endtask

   // Runs one tile. abort_at / rst_at: cycle index after the REQ entry
   // (0 = REQ of row 0) at which to cancel / reset, -1 for none.
   task automatic run_tile(input logic [7:0] b, input int rdy_pct, input int abort_at,
                           input bit poke, input bit hold, input int rst_at);
      logic [7:0] a;
      bit ended;
      int d0;
      flush();
      obs_addr.delete(); obs_data.delete(); obs_last.delete();
      for (int r = 0; r < TR; r++) begin
         a = 8'((int'(b) + r) % DEP);
         exp_addr.push_back(a);
         for (int l = 0; l < WPB; l++) begin
            exp_data.push_back(mem[a][l*DW +: DW]);
            exp_last.push_back(r == TR - 1 && l == WPB - 1);
         end
      end
      stalls = 0; busy_cyc = 0; d0 = done_cnt; ended = 0;
      base_addr = b; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 8'($urandom);
      chk("lat_bram_en", bram_en, 1);
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!busy) begin ended = 1; break; end
         if (cyc == rst_at) begin
            #2 rst_n = 1'b0;
            #1 chk("rst_outs", {bram_en, bram_addr, out_data, out_valid, out_last, busy, done}, 0);
            @(posedge clk); #1;
            chk("rst_hold_idle", busy, 0);
            rst_n = 1'b1;
            flush();
            return;
         end
         if (cyc == 2 && !(abort_at >= 0 && abort_at < 2))
            chk("lat_first_valid", out_valid, 1);
         if (hold) out_ready = !(cyc >= 4 && cyc <= 6);
         else      out_ready = ($urandom_range(99) < rdy_pct);
         if (poke && cyc == 3) begin start = 1'b1; base_addr = ~b; end
         abort = (cyc == abort_at);
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0;
         if (cyc == abort_at) begin
            chk("abort_idle", busy, 0);
            chk("abort_no_done", done_cnt - d0, 0);
            flush();
            return;
         end
      end
      if (!ended) chk("tile_timeout", 1, 0);
      chk("done_pulse", done_cnt - d0, 1);
      chk("tile_cycles", busy_cyc, TR * (WPB + 2) + 1 + stalls);
      chk("all_lanes_seen", exp_data.size(), 0);
   endtask

   task automatic chk_basic_lanes(input string nm);
      chk({nm, "_nlanes"}, obs_data.size(), 8);
      for (int i = 0; i < 8 && i < obs_data.size(); i++)
         chk({nm, "_lane"}, obs_data[i], i + 1);
      if (obs_last.size() == 8) begin
         chk({nm, "_last7"}, obs_last[7], 1);
         chk({nm, "_last6"}, obs_last[6], 0);
      end
   endtask

   initial begin
      rst_n = 1'b1; start = 0; abort = 0; out_ready = 0; base_addr = 0;
      for (int i = 0; i < DEP; i++) mem[i] = {$urandom, $urandom};
      mem[8'h10] = 64'h0004_0003_0002_0001;
      mem[8'h11] = 64'h0008_0007_0006_0005;
      #1 rst_n = 1'b0;
      #2 chk("reset_outs", {bram_en, bram_addr, out_data, out_valid, out_last, busy, done}, 0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

      // basic fetch
      run_tile(8'h10, 100, -1, 0, 0, -1);
      chk_basic_lanes("basic");
      chk("basic_cycles", busy_cyc, 13);
      if (obs_addr.size() == 2) begin
         chk("basic_addr0", obs_addr[0], 8'h10);
         chk("basic_addr1", obs_addr[1], 8'h11);
      end else chk("basic_naddr", obs_addr.size(), 2);

      // backpressure on lane 2 for three cycles
      run_tile(8'h10, 100, -1, 0, 1, -1);
      chk_basic_lanes("bp");
      chk("bp_stalls", stalls, 3);
      chk("bp_cycles", busy_cyc, 16);

      // address wrap
      run_tile(8'hFF, 100, -1, 0, 0, -1);
      if (obs_addr.size() == 2) begin
         chk("wrap_addr0", obs_addr[0], 8'hFF);
         chk("wrap_addr1", obs_addr[1], 8'h00);
      end else chk("wrap_naddr", obs_addr.size(), 2);

      // start while busy is ignored
      run_tile(8'h10, 100, -1, 1, 0, -1);
      chk_basic_lanes("poke");

      // abort in WAIT of row 1, then a clean fetch
      run_tile(8'h10, 100, WPB + 3, 0, 0, -1);
      run_tile(8'h10, 100, -1, 0, 0, -1);
      chk_basic_lanes("post_abort");

      // asynchronous reset mid-UNPACK, then a clean fetch
      run_tile(8'h10, 100, -1, 0, 0, 3);
      run_tile(8'h10, 100, -1, 0, 0, -1);
      chk_basic_lanes("post_rst");

      // randomized tiles
      for (int t = 0; t < 40; t++) begin
         int pct, ab;
         pct = (t % 3 == 0) ? 100 : ((t % 3 == 1) ? 70 : 30);
         ab  = ($urandom_range(3) == 0) ? int'($urandom_range(11)) : -1;
         run_tile(8'($urandom), pct, ab, $urandom_range(2) == 0, 0, -1);
         repeat ($urandom_range(2)) @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/tile_fetch.md
TILE_FETCH -- requirements
Module: tile_fetch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of one lane delivered to a MAC.
REQ-002 The block SHALL have parameter BRAM_W, default 64, meaning the BRAM word width; BRAM_W SHALL be a multiple of DATA_W, and WPB = BRAM_W/DATA_W.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 256, meaning BRAM depth; AW = $clog2(MEM_DEPTH).
REQ-004 The block SHALL have parameter TILE_ROWS, default 2, meaning the number of BRAM words fetched per tile, with TILE_ROWS >= 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk (input, 1 bit, rising-edge clock) and rst_n (input, 1 bit, asynchronous active-low reset).
REQ-006 The block SHALL have these ports:
- start, input, 1: one-cycle fetch request.
- abort, input, 1: synchronous cancel.
- base_addr, input, AW: tile base address, sampled on an accepted start.
- bram_en, output, 1: BRAM read enable.
- bram_addr, output, AW: BRAM read address.
- bram_rdata, input, BRAM_W: read data, valid exactly 1 cycle after bram_en.
- out_data, output, DATA_W: current lane.
- out_valid, output, 1: lane valid.
- out_ready, input, 1: consumer accepts the lane.
- out_last, output, 1: final lane of the tile.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle completion pulse.

Function
REQ-007 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, UNPACK, DONE.
REQ-008 In IDLE, start=1 SHALL be accepted: base_addr and row_cnt=0 are latched, and the next state is REQ; start in any other state SHALL be ignored.
REQ-009 REQ SHALL drive bram_en=1 and bram_addr=(base+row_cnt) mod MEM_DEPTH for exactly one cycle, then go to WAIT; the address SHALL wrap from MEM_DEPTH-1 to 0.
REQ-010 WAIT SHALL capture bram_rdata into the internal word register at the end of the cycle, set lane_idx=0, and go to UNPACK.
REQ-011 UNPACK SHALL drive out_valid=1 and out_data=word[lane_idx*DATA_W +: DATA_W], with lane 0 being the least-significant bits.
REQ-012 Lane advance SHALL happen only on out_valid&&out_ready; when out_ready=0, out_data and lane_idx SHALL hold, with no data loss.
REQ-013 On a handshake with lane_idx=WPB-1:
- if row_cnt<TILE_ROWS-1, row_cnt SHALL increment and the next state is REQ;
- otherwise the next state is DONE.
REQ-014 out_last SHALL be 1 only while in UNPACK with lane_idx=WPB-1 and row_cnt=TILE_ROWS-1.
REQ-015 DONE SHALL assert done=1 for one cycle and go to IDLE; busy SHALL be 1 in REQ, WAIT, UNPACK and DONE.
REQ-016 Latency SHALL be as follows:
- start accepted at edge k gives bram_en in cycle k+1 and first out_valid in cycle k+3;
- with out_ready held high, a tile takes TILE_ROWS*(WPB+2)+1 cycles from REQ entry to IDLE.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with no done pulse.
REQ-018 An abort coincident with an out handshake SHALL discard that lane's progress, and abort SHALL take priority over start.
REQ-019 bram_en SHALL be 0 outside REQ, and out_valid SHALL be 0 outside UNPACK.
REQ-020 The block SHALL NOT issue a second BRAM read until all WPB lanes of the current word have been accepted.
REQ-021 All counters SHALL be sized to hold their maximum value without overflow: row_cnt holds TILE_ROWS-1 and lane_idx holds WPB-1.

Reset
REQ-022 While rst_n=0, the state SHALL be IDLE and every output SHALL be 0: bram_en, bram_addr, out_data, out_valid, out_last, busy, done.
REQ-023 Reset assertion SHALL take effect immediately, without a clock edge, even mid-tile; the word register, row_cnt and lane_idx SHALL clear to 0.
REQ-024 After rst_n deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-025 Basic fetch. Stimulus: defaults, base_addr=8'h10, start pulse, out_ready=1, BRAM holding 64'h0004_0003_0002_0001 at 0x10 and 64'h0008_0007_0006_0005 at 0x11. Required response:
- bram_addr=0x10 then 0x11;
- out_data 1,2,3,4,5,6,7,8;
- out_last on 8;
- done one cycle later;
- 13 cycles from REQ entry to IDLE.
REQ-026 Backpressure. Stimulus: as REQ-025, with out_ready=0 for 3 cycles on lane 2. Required response: out_data=3 held stable with out_valid=1; the sequence is unchanged; total time increases by exactly 3 cycles.
REQ-027 Address wrap. Stimulus: base_addr=8'hFF, TILE_ROWS=2. Required response: bram_addr=0xFF then 0x00.
REQ-028 Start while busy. Stimulus: start pulse during UNPACK with a different base_addr. Required response: ignored, with no change to addresses or outputs.
REQ-029 Abort. Stimulus: abort during WAIT of row 1. Required response: IDLE on the next cycle, busy=0, no done, and a subsequent start fetches normally.
REQ-030 Mid-tile reset. Stimulus: rst_n=0 asynchronously during UNPACK. Required response: all outputs 0 before the next edge, and a fetch after release is correct.
